cache_victim_buffer: RTL and testbench
======================================

Name: cache_victim_buffer

Overview:
- Multi-entry write-back victim buffer between the D$ and the AHB cache bus interface.
- Dirty lines evicted on a miss are enqueued in one cycle, so the line fill can start at once; buffered lines drain to memory in the background.
- Successor to the single-line writeback path: adds parametrised depth, a drain threshold, a level-sensitive flush, and read forwarding of buffered lines to pending misses.

Parameters:
PA_BITS, 32, physical address width
LINELEN, 512, cache line width in bits
NUMENTRIES, 4, buffer depth; power of two, >=2
DRAIN_THRESHOLD, 1, occupancy at which background drain starts (1 = eager drain); 1..NUMENTRIES

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
EnqValid  input  1  cache presents a victim line
EnqReady  output  1  buffer can accept; equals ~Full
EnqAdr  input  PA_BITS  line-aligned victim address (low log2(LINELEN/8) bits ignored)
EnqLine  input  LINELEN  victim line data
LookupAdr  input  PA_BITS  miss address to check against buffered lines
LookupHit  output  1  some valid entry holds the LookupAdr line
LookupLine  output  LINELEN  data of the youngest matching entry; 0 when no hit
BusWrite  output  1  request line write to the bus interface
BusAdr  output  PA_BITS  head entry address, offset bits zero
BusLine  output  LINELEN  head entry data
BusAck  input  1  bus write of the head line complete
FlushReq  input  1  level: drain everything, ignoring the threshold
FlushDone  output  1  FlushReq & Empty & state IDLE
Count  output  $clog2(NUMENTRIES)+1  occupied entries

Behaviour:
- Storage: circular array. Head and tail pointers are $clog2(NUMENTRIES)+1 bits; the MSB is the wrap bit.
  - Empty = pointers equal.
  - Full = index bits equal and wrap bits differ.
  - Count = tail - head, modulo 2^(width).
- Enqueue: on EnqValid & EnqReady, the tail entry is written and marked valid, and tail increments. It wraps from NUMENTRIES-1 to 0 and toggles the wrap bit.
- EnqReady is derived from registered state only. When Full, it stays 0 even if a pop happens in the same cycle.
- Drain FSM, states IDLE and WRITE:
  - IDLE->WRITE when Count >= DRAIN_THRESHOLD, or when FlushReq & ~Empty.
  - In WRITE: BusWrite=1. BusAdr and BusLine are driven from the head entry and stay stable until BusAck.
  - WRITE on BusAck: head entry is invalidated and head increments.
    - Stay in WRITE if the post-pop Count >= DRAIN_THRESHOLD, or if FlushReq and the post-pop Count != 0.
    - Otherwise go to IDLE.
  - BusWrite deasserts on the cycle after the final BusAck.
  - BusAck while in IDLE is ignored.
- Simultaneous enqueue and pop: both take effect and Count is unchanged.
- Lookup:
  - Combinational compare of LookupAdr[PA_BITS-1:OFFSET] against every valid entry.
  - Only registered entries participate. A same-cycle enqueue is not visible until the next cycle.
  - Multiple matches: the youngest entry (closest to tail) wins.
  - Drain order is FIFO, so memory ends up holding the youngest copy.
  - The head entry in flight on the bus still hits until the cycle after its BusAck.
- Duplicates: a line may be enqueued while an older copy is still buffered. No coalescing is performed.
- Flush:
  - While FlushReq is held, the FSM drains until Empty.
  - Enqueues during a flush are accepted and drained as well.
  - FlushDone is combinational from registered state; the cache FSM holds FlushReq until it sees FlushDone.
- Reset (reset_n low at a clock edge), including mid-drain:
  - head=tail=0, all valid bits clear, state IDLE.
  - An in-flight bus write is abandoned; the bus interface is reset together with this block.
  - Outputs after reset: EnqReady=1, BusWrite=0, LookupHit=0, LookupLine=0, Count=0, FlushDone=0.
  - Entry data arrays are not reset.

Decomposition:
- Shared package cvw: typedef enum {VB_IDLE, VB_WRITE} victimbufstate_t.
- Offset width is derived locally from LINELEN.
- One sub-module, cache_victim_match: parametrised CAM compare plus youngest-first priority select. Inputs are valid bits, tags, head pointer and lookup tag; outputs are the hit flag and a one-hot select, which drives an AO mux.

Test Plan:
- Eager drain: DRAIN_THRESHOLD=1; enqueue line 0x8000_0040 -> BusWrite=1 next cycle with BusAdr=0x8000_0040; BusAck after 3 cycles -> Count 1->0, BusWrite=0 the following cycle.
- Fill to full: DRAIN_THRESHOLD=4, NUMENTRIES=4, BusAck held 0; enqueue 4 lines -> EnqReady=0 and Count=4; a 5th EnqValid is not accepted.
  - Then BusAck once -> head 0 pops, EnqReady=1 the next cycle, and the 5th line is accepted into index 0 with the wrap bit toggled.
- Forwarding with duplicates: enqueue 0x1000 (data A), then 0x2000, then 0x1000 (data B); LookupAdr=0x1010 -> LookupHit=1, LookupLine=B.
  - After all three drain -> LookupHit=0 and bus write order is 0x1000/A, 0x2000, 0x1000/B.
- Flush: DRAIN_THRESHOLD=4 with 2 entries buffered and FSM in IDLE; raise FlushReq -> both lines drain and FlushDone=1 once Empty.
  - An enqueue injected mid-flush is also drained before FlushDone.
- Simultaneous enq/pop at Count=2 -> Count stays 2 and the pointers advance by one each.
- Reset mid-WRITE: drop reset_n for 1 cycle while BusWrite=1 with 3 entries -> Count=0, BusWrite=0, EnqReady=1, and a subsequent lookup of any prior address misses.

Source files
------------

// File: rtl/cache_victim_buffer_pkg.sv
// Shared types for the D$ victim buffer.
package cvw;

  typedef enum logic [0:0] {
    VB_IDLE,
    VB_WRITE
  } victimbufstate_t;

endpackage

// File: rtl/cache_victim_match.sv
// CAM compare of a lookup tag against all buffered tags, with youngest-first priority select.
module cache_victim_match #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned TagBits    = 26,
  localparam int unsigned IdxBits   = $clog2(NumEntries)
) (
  input  logic [NumEntries-1:0]              valid_i,
  input  logic [NumEntries-1:0][TagBits-1:0] tags_i,
  input  logic [IdxBits-1:0]                 head_i,
  input  logic [TagBits-1:0]                 lookup_tag_i,
  output logic                               hit_o,
  output logic [NumEntries-1:0]              sel_o
);

  logic [NumEntries-1:0] match;

  // Per-entry tag compare, qualified by valid.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      match[i] = valid_i[i] && (tags_i[i] == lookup_tag_i);
    end
  end

  // Walk from head (oldest) towards tail; a later match overrides, so the youngest wins.
  always_comb begin
    logic [IdxBits-1:0] idx;
    hit_o = 1'b0;
    sel_o = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NumEntries; k++) begin
      idx = head_i + IdxBits'(k);
      if (match[idx]) begin
        sel_o      = '0;
        sel_o[idx] = 1'b1;
        hit_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_victim_buffer.sv
// Multi-entry write-back victim buffer: single-cycle enqueue of evicted dirty lines,
// background FIFO drain to the bus, and read forwarding of buffered lines to misses.
module cache_victim_buffer import cvw::*; #(
  parameter int unsigned PA_BITS         = 32,
  parameter int unsigned LINELEN         = 512,
  parameter int unsigned NUMENTRIES      = 4,
  parameter int unsigned DRAIN_THRESHOLD = 1,
  localparam int unsigned CntBits        = $clog2(NUMENTRIES) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               EnqValid,
  output logic               EnqReady,
  input  logic [PA_BITS-1:0] EnqAdr,
  input  logic [LINELEN-1:0] EnqLine,
  input  logic [PA_BITS-1:0] LookupAdr,
  output logic               LookupHit,
  output logic [LINELEN-1:0] LookupLine,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [LINELEN-1:0] BusLine,
  input  logic               BusAck,
  input  logic               FlushReq,
  output logic               FlushDone,
  output logic [CntBits-1:0] Count
);

  localparam int unsigned OffBits = $clog2(LINELEN / 8);
  localparam int unsigned TagBits = PA_BITS - OffBits;
  localparam int unsigned IdxBits = $clog2(NUMENTRIES);

  // Pointers carry a wrap bit above the index so full and empty are distinguishable.
  logic [CntBits-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [NUMENTRIES-1:0]              valid_q, valid_d;
  logic [NUMENTRIES-1:0][TagBits-1:0] tag_q;
  logic [LINELEN-1:0]                 data_q [NUMENTRIES];
  victimbufstate_t                    state_q, state_d;

  logic [IdxBits-1:0]    head_idx, tail_idx;
  logic                  empty, full, enq, pop;
  logic [CntBits-1:0]    post_pop;
  logic                  hit;
  logic [NUMENTRIES-1:0] sel;
  logic                  unused_offsets;

  assign head_idx = head_q[IdxBits-1:0];
  assign tail_idx = tail_q[IdxBits-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[CntBits-1] != tail_q[CntBits-1]);
  assign Count    = tail_q - head_q;
  assign post_pop = Count - CntBits'(1);

  assign EnqReady = ~full;
  assign enq      = EnqValid & ~full;
  assign pop      = (state_q == VB_WRITE) & BusAck;

  // Line-offset address bits carry no information for a line-granular buffer.
  assign unused_offsets = ^{EnqAdr[OffBits-1:0], LookupAdr[OffBits-1:0]};

  // Pointer and valid-bit next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (pop) begin
      head_d            = head_q + CntBits'(1);
      valid_d[head_idx] = 1'b0;
    end
    if (enq) begin
      tail_d            = tail_q + CntBits'(1);
      valid_d[tail_idx] = 1'b1;
    end
  end

  // Drain FSM: threshold-triggered, or forced by a held flush request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VB_IDLE: begin
        if ((Count >= CntBits'(DRAIN_THRESHOLD)) || (FlushReq && !empty)) state_d = VB_WRITE;
      end
      VB_WRITE: begin
        if (BusAck) begin
          if ((post_pop >= CntBits'(DRAIN_THRESHOLD)) || (FlushReq && (post_pop != '0))) begin
            state_d = VB_WRITE;
          end else begin
            state_d = VB_IDLE;
          end
        end
      end
      default: state_d = VB_IDLE;
    endcase
  end

  // Control state with synchronous reset; an in-flight bus write is simply abandoned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      state_q <= VB_IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  // Entry tag/data storage, not reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      tag_q[tail_idx]  <= EnqAdr[PA_BITS-1:OffBits];
      data_q[tail_idx] <= EnqLine;
    end
  end

  cache_victim_match #(
    .NumEntries (NUMENTRIES),
    .TagBits    (TagBits)
  ) u_match (
    .valid_i      (valid_q),
    .tags_i       (tag_q),
    .head_i       (head_idx),
    .lookup_tag_i (LookupAdr[PA_BITS-1:OffBits]),
    .hit_o        (hit),
    .sel_o        (sel)
  );

  // AND-OR mux of the one-hot selected entry; yields zero on a miss.
  always_comb begin
    LookupLine = '0;
    for (int unsigned i = 0; i < NUMENTRIES; i++) begin
      LookupLine = LookupLine | (data_q[i] & {LINELEN{sel[i]}});
    end
  end

  assign LookupHit = hit;
  assign BusWrite  = (state_q == VB_WRITE);
  assign BusAdr    = {tag_q[head_idx], {OffBits{1'b0}}};
  assign BusLine   = data_q[head_idx];
  assign FlushDone = FlushReq & empty & (state_q == VB_IDLE);

endmodule

// File: tb/tb_cache_victim_buffer.sv
// Randomized plus directed bench for two victim buffers (eager and threshold-4 drain)
// driven by the same stimulus, each checked against a queue-level reference model.
module tb_cache_victim_buffer;

  localparam int N  = 4;
  localparam int LL = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          EnqValid;
  logic [31:0]   EnqAdr;
  logic [LL-1:0] EnqLine;
  logic [31:0]   LookupAdr;
  logic          BusAck;
  logic          FlushReq;

  logic          enq_ready   [2];
  logic          lookup_hit  [2];
  logic [LL-1:0] lookup_line [2];
  logic          bus_write   [2];
  logic [31:0]   bus_adr     [2];
  logic [LL-1:0] bus_line    [2];
  logic          flush_done  [2];
  logic [2:0]    count       [2];

  cache_victim_buffer #(.NUMENTRIES(N), .DRAIN_THRESHOLD(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .EnqValid(EnqValid), .EnqReady(enq_ready[0]),
    .EnqAdr(EnqAdr), .EnqLine(EnqLine), .LookupAdr(LookupAdr), .LookupHit(lookup_hit[0]),
    .LookupLine(lookup_line[0]), .BusWrite(bus_write[0]), .BusAdr(bus_adr[0]),
    .BusLine(bus_line[0]), .BusAck(BusAck), .FlushReq(FlushReq), .FlushDone(flush_done[0]),
    .Count(count[0])
  );

  cache_victim_buffer #(.NUMENTRIES(N), .DRAIN_THRESHOLD(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .EnqValid(EnqValid), .EnqReady(enq_ready[1]),
    .EnqAdr(EnqAdr), .EnqLine(EnqLine), .LookupAdr(LookupAdr), .LookupHit(lookup_hit[1]),
    .LookupLine(lookup_line[1]), .BusWrite(bus_write[1]), .BusAdr(bus_adr[1]),
    .BusLine(bus_line[1]), .BusAck(BusAck), .FlushReq(FlushReq), .FlushDone(flush_done[1]),
    .Count(count[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per buffer, a FIFO of (line address, data) plus a draining flag.
  int          thr    [2] = '{1, 4};
  logic [31:0] m_adr  [2][N];
  logic [LL-1:0] m_line [2][N];
  int          m_cnt  [2];
  int          m_hd   [2];
  bit          m_busy [2];

  logic [31:0] pool [6] = '{32'h8000_0040, 32'h0000_1000, 32'h0000_2000,
                            32'h0000_3000, 32'h1234_5680, 32'h0000_1040};

  task automatic check_eq(input string tag, input logic [LL-1:0] got, input logic [LL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LL-1:0] rand_line();
    logic [LL-1:0] r;
    for (int i = 0; i < LL / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] rand_adr();
    return pool[$urandom_range(0, 5)] | ($urandom & 32'h3F);
  endfunction

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      logic          exp_hit;
      logic [LL-1:0] exp_line;
      string         p;
      p        = $sformatf("thr%0d.", thr[d]);
      exp_hit  = 1'b0;
      exp_line = '0;
      for (int k = m_cnt[d] - 1; k >= 0; k--) begin
        int ix;
        ix = (m_hd[d] + k) % N;
        if (!exp_hit && (m_adr[d][ix][31:6] == LookupAdr[31:6])) begin
          exp_hit  = 1'b1;
          exp_line = m_line[d][ix];
        end
      end
      check_eq({p, "EnqReady"}, LL'(enq_ready[d]), LL'(m_cnt[d] < N));
      check_eq({p, "Count"}, LL'(count[d]), LL'(m_cnt[d]));
      check_eq({p, "BusWrite"}, LL'(bus_write[d]), LL'(m_busy[d]));
      check_eq({p, "LookupHit"}, LL'(lookup_hit[d]), LL'(exp_hit));
      check_eq({p, "LookupLine"}, lookup_line[d], exp_line);
      check_eq({p, "FlushDone"}, LL'(flush_done[d]),
               LL'(FlushReq && (m_cnt[d] == 0) && !m_busy[d]));
      if (m_busy[d]) begin
        check_eq({p, "BusAdr"}, LL'(bus_adr[d]), LL'(m_adr[d][m_hd[d]]));
        check_eq({p, "BusLine"}, bus_line[d], m_line[d][m_hd[d]]);
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_cnt[d]  = 0;
        m_hd[d]   = 0;
        m_busy[d] = 1'b0;
      end else begin
        bit do_enq;
        do_enq = EnqValid && (m_cnt[d] < N);
        if (m_busy[d] && BusAck) begin
          m_hd[d]   = (m_hd[d] + 1) % N;
          m_cnt[d]  = m_cnt[d] - 1;
          m_busy[d] = (m_cnt[d] >= thr[d]) || (FlushReq && m_cnt[d] != 0);
        end else if (!m_busy[d]) begin
          m_busy[d] = (m_cnt[d] >= thr[d]) || (FlushReq && m_cnt[d] != 0);
        end
        if (do_enq) begin
          m_adr[d][(m_hd[d] + m_cnt[d]) % N]  = EnqAdr & ~32'h3F;
          m_line[d][(m_hd[d] + m_cnt[d]) % N] = EnqLine;
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then cross the rising edge.
  task automatic step(input logic ev, input logic [31:0] ea, input logic ack, input logic fl,
                      input logic [31:0] la, input logic rn);
    EnqValid  = ev;
    EnqAdr    = ea;
    EnqLine   = rand_line();
    BusAck    = ack;
    FlushReq  = fl;
    LookupAdr = la;
    reset_n   = rn;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic bit all_idle();
    return (m_cnt[0] == 0) && !m_busy[0] && (m_cnt[1] == 0) && !m_busy[1];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fl_hold;
    reset_n = 1'b0; EnqValid = 1'b0; EnqAdr = '0; EnqLine = '0;
    LookupAdr = '0; BusAck = 1'b0; FlushReq = 1'b0;
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rst.EnqReady", LL'(enq_ready[0]), LL'(1'b1));
    check_eq("rst.Count", LL'(count[1]), LL'(0));
    check_eq("rst.BusWrite", LL'(bus_write[0]), LL'(1'b0));

    // Eager drain of a single line with a delayed ack.
    step(1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h8000_0040, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 32'h8000_0040, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 32'h8000_0040, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 32'h8000_0040, 1'b1);

    // Fill to full, blocked fifth enqueue, then a pop frees a slot with pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, pool[i], 1'b0, 1'b0, pool[0], 1'b1);
    check_eq("full.EnqReady", LL'(enq_ready[1]), LL'(1'b0));
    step(1'b1, pool[4], 1'b1, 1'b0, pool[4], 1'b1);
    step(1'b1, pool[4], 1'b0, 1'b0, pool[4], 1'b1);
    for (int i = 0; i < 40 && !all_idle(); i++) step(1'b0, '0, 1'b1, 1'b1, pool[4], 1'b1);

    // Duplicate lines: youngest copy forwards; FIFO drain order is checked on BusAdr/BusLine.
    step(1'b1, 32'h1000, 1'b0, 1'b0, 32'h1010, 1'b1);
    step(1'b1, 32'h2000, 1'b0, 1'b0, 32'h1010, 1'b1);
    step(1'b1, 32'h1000, 1'b0, 1'b0, 32'h1010, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 32'h1010, 1'b1);
    check_eq("dup.LookupHit", LL'(lookup_hit[1]), LL'(1'b1));
    for (int i = 0; i < 40 && !all_idle(); i++) step(1'b0, '0, 1'b1, 1'b1, 32'h1010, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 32'h1010, 1'b1);

    // Flush below threshold, with an enqueue injected mid-flush.
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h3000, 1'b1);
    step(1'b1, 32'h4000, 1'b0, 1'b0, 32'h3000, 1'b1);
    for (int i = 0; i < 60 && !(i > 3 && all_idle()); i++)
      step(i == 3, 32'h5000, 1'($urandom_range(0, 1)), 1'b1, 32'h5000, 1'b1);
    check_eq("flush.FlushDone", LL'(flush_done[1]), LL'(1'b1));
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Reset in the middle of a bus write with three entries buffered.
    for (int i = 0; i < 3; i++) step(1'b1, pool[i], 1'b0, 1'b0, pool[0], 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, pool[0], 1'b0);
    check_eq("rstmid.Count", LL'(count[0]), LL'(0));
    check_eq("rstmid.BusWrite", LL'(bus_write[0]), LL'(1'b0));
    check_eq("rstmid.LookupHit", LL'(lookup_hit[0]), LL'(1'b0));
    step(1'b0, '0, 1'b0, 1'b0, pool[1], 1'b1);

    // Random traffic: enqueues, acks, flush bursts, occasional reset.
    fl_hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) fl_hold = ~fl_hold;
      step(1'($urandom_range(0, 1)), rand_adr(), 1'($urandom_range(0, 9) < 4), fl_hold,
           rand_adr(), 1'($urandom_range(0, 199) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
